// File: rtl/snitch_icache_refill_serializer.sv
// rtl/snitch_icache_refill_serializer.sv - serializes one icache line refill into narrow memory beats
//
// Takes one line refill request at a time, issues LINE_WIDTH/MEM_DW in-order
// beat reads on the memory port, assembles the returned beats into a line and
// hands line, sticky error and id back in a single response handshake.
//
// Ports:
//   clk_i, rst_i                     clock, asynchronous active-high reset
//   in_req_{addr,id,valid}_i, in_req_ready_o
//                                    line refill request from the miss handler
//   in_rsp_{data,error,id,valid}_o, in_rsp_ready_i
//                                    assembled line back to the miss handler
//   mem_req_{addr,valid}_o, mem_req_ready_i
//                                    beat read requests
//   mem_rsp_{data,error,valid}_i, mem_rsp_ready_o
//                                    beat read responses, in request order
module snitch_icache_refill_serializer #(
  parameter int unsigned FETCH_AW   = 48,
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned MEM_DW     = 64,
  parameter int unsigned PENDING_IW = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [FETCH_AW-1:0]   in_req_addr_i,
  input  logic [PENDING_IW-1:0] in_req_id_i,
  input  logic                  in_req_valid_i,
  output logic                  in_req_ready_o,
  output logic [LINE_WIDTH-1:0] in_rsp_data_o,
  output logic                  in_rsp_error_o,
  output logic [PENDING_IW-1:0] in_rsp_id_o,
  output logic                  in_rsp_valid_o,
  input  logic                  in_rsp_ready_i,
  output logic [FETCH_AW-1:0]   mem_req_addr_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  input  logic [MEM_DW-1:0]     mem_rsp_data_i,
  input  logic                  mem_rsp_error_i,
  input  logic                  mem_rsp_valid_i,
  output logic                  mem_rsp_ready_o
);

  localparam int unsigned BEATS      = LINE_WIDTH / MEM_DW;
  localparam int unsigned LINE_ALIGN = $clog2(LINE_WIDTH / 8);
  localparam int unsigned BEAT_SHIFT = $clog2(MEM_DW / 8);
  localparam int unsigned CW         = $clog2(BEATS + 1);

  // Clears the byte-within-line bits of the request address.
  localparam logic [FETCH_AW-1:0] ALIGN_MASK =
      ~((FETCH_AW'(1) << LINE_ALIGN) - FETCH_AW'(1));

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_e;

  state_e                state_q;
  logic [CW-1:0]         issue_cnt_q;
  logic [CW-1:0]         rcv_cnt_q;
  logic [FETCH_AW-1:0]   base_q;
  logic [LINE_WIDTH-1:0] data_q;
  logic                  err_q;
  logic [PENDING_IW-1:0] id_q;

  logic req_hs, mem_req_hs, mem_rsp_hs;
  logic issue_last, rcv_last;

  assign req_hs     = in_req_valid_i & in_req_ready_o;
  assign mem_req_hs = mem_req_valid_o & mem_req_ready_i;
  assign mem_rsp_hs = mem_rsp_valid_i & mem_rsp_ready_o;
  assign issue_last = (issue_cnt_q == CW'(BEATS - 1));
  assign rcv_last   = (rcv_cnt_q == CW'(BEATS - 1));

  // Beat address wraps within FETCH_AW; a line never straddles the top
  // because the base is line aligned.
  assign mem_req_addr_o = base_q + (FETCH_AW'(issue_cnt_q) << BEAT_SHIFT);
  assign in_rsp_data_o  = data_q;
  assign in_rsp_error_o = err_q;
  assign in_rsp_id_o    = id_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      issue_cnt_q     <= '0;
      rcv_cnt_q       <= '0;
      base_q          <= '0;
      data_q          <= '0;
      err_q           <= 1'b0;
      id_q            <= '0;
      in_req_ready_o  <= 1'b1;
      in_rsp_valid_o  <= 1'b0;
      mem_req_valid_o <= 1'b0;
      mem_rsp_ready_o <= 1'b0;
    end else begin
      // Beat collection runs independently of issue so responses can
      // overlap outstanding requests.
      if (mem_rsp_hs) begin
        for (int k = 0; k < BEATS; k++) begin
          if (rcv_cnt_q == CW'(k)) data_q[k*MEM_DW +: MEM_DW] <= mem_rsp_data_i;
        end
        err_q     <= err_q | mem_rsp_error_i;
        rcv_cnt_q <= rcv_cnt_q + CW'(1);
      end
      if (mem_req_hs) issue_cnt_q <= issue_cnt_q + CW'(1);

      unique case (state_q)
        IDLE: begin
          if (req_hs) begin
            base_q          <= in_req_addr_i & ALIGN_MASK;
            id_q            <= in_req_id_i;
            err_q           <= 1'b0;
            issue_cnt_q     <= '0;
            rcv_cnt_q       <= '0;
            state_q         <= ISSUE;
            in_req_ready_o  <= 1'b0;
            mem_req_valid_o <= 1'b1;
            mem_rsp_ready_o <= 1'b1;
          end
        end
        ISSUE: begin
          if (mem_req_hs && issue_last) begin
            mem_req_valid_o <= 1'b0;
            // The last response may land in the same cycle as the last request.
            if (mem_rsp_hs && rcv_last) begin
              state_q         <= RESP;
              mem_rsp_ready_o <= 1'b0;
              in_rsp_valid_o  <= 1'b1;
            end else begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (mem_rsp_hs && rcv_last) begin
            state_q         <= RESP;
            mem_rsp_ready_o <= 1'b0;
            in_rsp_valid_o  <= 1'b1;
          end
        end
        RESP: begin
          // Ready for the next request only after this handshake: one bubble.
          if (in_rsp_ready_i) begin
            state_q        <= IDLE;
            in_rsp_valid_o <= 1'b0;
            in_req_ready_o <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  // Responses are only legal while a beat is still expected.
  int unsigned stray_rsp_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stray_rsp_cnt <= 0;
    else if (mem_rsp_valid_i && !mem_rsp_ready_o) stray_rsp_cnt <= stray_rsp_cnt + 1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(mem_rsp_valid_i && !mem_rsp_ready_o))
        else $warning("stray mem_rsp_valid_i ignored while no beat is expected");
    end
  end
`endif

endmodule

// File: tb/tb_snitch_icache_refill_serializer.sv
// tb/tb_snitch_icache_refill_serializer.sv - scoreboard bench for the icache refill serializer
module tb_snitch_icache_refill_serializer;

  localparam int AW = 32;
  localparam int LW = 128;
  localparam int DW = 32;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [AW-1:0] in_req_addr_i;
  logic [IW-1:0] in_req_id_i;
  logic          in_req_valid_i;
  logic          in_req_ready_o;
  logic [LW-1:0] in_rsp_data_o;
  logic          in_rsp_error_o;
  logic [IW-1:0] in_rsp_id_o;
  logic          in_rsp_valid_o;
  logic          in_rsp_ready_i;
  logic [AW-1:0] mem_req_addr_o;
  logic          mem_req_valid_o;
  logic          mem_req_ready_i;
  logic [DW-1:0] mem_rsp_data_i;
  logic          mem_rsp_error_i;
  logic          mem_rsp_valid_i;
  logic          mem_rsp_ready_o;

  snitch_icache_refill_serializer #(
    .FETCH_AW  (AW),
    .LINE_WIDTH(LW),
    .MEM_DW    (DW),
    .PENDING_IW(IW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .in_req_addr_i  (in_req_addr_i),
    .in_req_id_i    (in_req_id_i),
    .in_req_valid_i (in_req_valid_i),
    .in_req_ready_o (in_req_ready_o),
    .in_rsp_data_o  (in_rsp_data_o),
    .in_rsp_error_o (in_rsp_error_o),
    .in_rsp_id_o    (in_rsp_id_o),
    .in_rsp_valid_o (in_rsp_valid_o),
    .in_rsp_ready_i (in_rsp_ready_i),
    .mem_req_addr_o (mem_req_addr_o),
    .mem_req_valid_o(mem_req_valid_o),
    .mem_req_ready_i(mem_req_ready_i),
    .mem_rsp_data_i (mem_rsp_data_i),
    .mem_rsp_error_i(mem_rsp_error_i),
    .mem_rsp_valid_i(mem_rsp_valid_i),
    .mem_rsp_ready_o(mem_rsp_ready_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] addr;
    int          cyc;
  } beat_t;

  typedef struct packed {
    logic [LW-1:0] data;
    logic          err;
    logic [IW-1:0] id;
  } line_t;

  logic [31:0] exp_addr_q[$];
  beat_t       out_q[$];
  line_t       exp_line_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  bit          toggle_mode = 0;
  bit          gap_mode    = 0;
  bit          err_en      = 0;
  bit          stray_drive = 0;
  logic [31:0] err_addr    = '0;
  int          rsp_hold    = 0;
  int          issued_cnt  = 0;
  int          rsp_beats   = 0;
  int          last_rsp_cyc = 0;
  bit          rsp_seen    = 0;
  bit          chk_bubble  = 0;

  task automatic check_eq(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] beat_data(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Memory model: in-order responses, at least one cycle after the request.
  initial begin : mem_model
    beat_t       b;
    logic [31:0] exp_a;
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = '0;
    mem_rsp_error_i = 1'b0;
    forever begin
      @(negedge clk);
      mem_req_ready_i = toggle_mode ? ~mem_req_ready_i : 1'b1;
      if (!rst_i && mem_req_valid_o && mem_req_ready_i) begin
        exp_a = (exp_addr_q.size() == 0) ? 32'hDEAD_BEEF : exp_addr_q.pop_front();
        check_eq("mem_req_addr", mem_req_addr_o, exp_a);
        out_q.push_back('{addr: mem_req_addr_o, cyc: cyc});
        issued_cnt++;
      end
      mem_rsp_valid_i = 1'b0;
      mem_rsp_error_i = 1'b0;
      if (stray_drive) begin
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = 32'hBAD0_BAD0;
        mem_rsp_error_i = 1'b1;
      end else if (!rst_i && out_q.size() > 0 && out_q[0].cyc < cyc && mem_rsp_ready_o
                   && !(gap_mode && $urandom_range(0, 1) == 0)) begin
        b = out_q.pop_front();
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = beat_data(b.addr);
        mem_rsp_error_i = err_en && (b.addr == err_addr);
        rsp_beats++;
        if (rsp_beats % 4 == 0) last_rsp_cyc = cyc;
      end
    end
  end

  // Line response checker; also owns in_rsp_ready_i.
  initial begin : rsp_model
    in_rsp_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_bubble) begin
        check_eq("bubble_req_ready", in_req_ready_o, 1);
        chk_bubble = 0;
      end
      in_rsp_ready_i = 1'b0;
      if (!rst_i && in_rsp_valid_o) begin
        if (exp_line_q.size() == 0) begin
          check_eq("rsp_unexpected", in_rsp_valid_o, 0);
        end else begin
          if (!rsp_seen) begin
            check_eq("rsp_latency", cyc, last_rsp_cyc + 1);
            rsp_seen = 1;
          end
          check_eq("rsp_data", in_rsp_data_o, exp_line_q[0].data);
          check_eq("rsp_error", in_rsp_error_o, exp_line_q[0].err);
          check_eq("rsp_id", in_rsp_id_o, exp_line_q[0].id);
          check_eq("rsp_req_ready", in_req_ready_o, 0);
          check_eq("rsp_mem_valid", mem_req_valid_o, 0);
          if (rsp_hold > 0) begin
            rsp_hold--;
          end else begin
            in_rsp_ready_i = 1'b1;
            void'(exp_line_q.pop_front());
            rsp_seen   = 0;
            chk_bubble = 1;
          end
        end
      end
    end
  end

  task automatic start_refill(input logic [31:0] addr, input logic [IW-1:0] id);
    line_t       l;
    logic [31:0] base;
    logic [31:0] a;
    int          t;
    l    = '0;
    base = addr & 32'hFFFF_FFF0;
    for (int k = 0; k < 4; k++) begin
      a = base + 32'(4 * k);
      exp_addr_q.push_back(a);
      l.data[k*DW +: DW] = beat_data(a);
      l.err = l.err | (err_en && (a == err_addr));
    end
    l.id = id;
    exp_line_q.push_back(l);
    in_req_addr_i  = addr;
    in_req_id_i    = id;
    in_req_valid_i = 1'b1;
    t = 0;
    while (!in_req_ready_o && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_eq("req_accept", in_req_ready_o, 1);
    @(negedge clk);
    in_req_valid_i = 1'b0;
    check_eq("first_req_lat", mem_req_valid_o, 1);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (exp_line_q.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check_eq("line_done", exp_line_q.size(), 0);
    check_eq("beats_all_issued", exp_addr_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_req_ready"}, in_req_ready_o, 1);
    check_eq({tag, "_rsp_valid"}, in_rsp_valid_o, 0);
    check_eq({tag, "_rsp_data"}, in_rsp_data_o, 0);
    check_eq({tag, "_rsp_error"}, in_rsp_error_o, 0);
    check_eq({tag, "_rsp_id"}, in_rsp_id_o, 0);
    check_eq({tag, "_mem_valid"}, mem_req_valid_o, 0);
    check_eq({tag, "_mem_addr"}, mem_req_addr_o, 0);
    check_eq({tag, "_mem_rsp_ready"}, mem_rsp_ready_o, 0);
  endtask

  initial begin : main
    int t;
    rst_i          = 1'b1;
    in_req_addr_i  = '0;
    in_req_id_i    = '0;
    in_req_valid_i = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);

    // Basic refill, memory always ready.
    start_refill(32'h1234_5678, 2'd2);
    wait_done();

    // Toggling request ready and random response gaps.
    toggle_mode = 1;
    gap_mode    = 1;
    start_refill(32'h1234_5678, 2'd2);
    wait_done();
    toggle_mode = 0;
    gap_mode    = 0;

    // Beat 2 errors; the next refill must come back clean.
    err_en   = 1;
    err_addr = 32'h0000_A008;
    start_refill(32'h0000_A00C, 2'd1);
    wait_done();
    start_refill(32'h0000_B004, 2'd3);
    wait_done();
    err_en = 0;

    // Response back-pressure for 5 cycles.
    rsp_hold = 5;
    start_refill(32'h0000_4444, 2'd0);
    wait_done();

    // Asynchronous reset after two beats issued.
    issued_cnt = 0;
    start_refill(32'h0000_8000, 2'd1);
    t = 0;
    while (issued_cnt < 2 && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    #2 rst_i = 1'b1;
    #1 check_idle_outputs("midrst");
    exp_addr_q.delete();
    out_q.delete();
    exp_line_q.delete();
    rsp_beats = 0;
    rsp_seen  = 0;
    @(negedge clk);
    #2 rst_i = 1'b0;
    @(negedge clk);
    start_refill(32'h0000_8010, 2'd2);
    wait_done();

    // Top-of-address-space line, then a stray response while idle.
    start_refill(32'hFFFF_FFF4, 2'd3);
    wait_done();
    #2 stray_drive = 1;
    @(negedge clk);
    #1 check_eq("stray_not_ready", mem_rsp_ready_o, 0);
    stray_drive = 0;
    @(negedge clk);
    @(negedge clk);
    check_eq("stray_flagged", dut.stray_rsp_cnt, 1);
    check_eq("stray_no_rsp", in_rsp_valid_o, 0);
    start_refill(32'h0000_1230, 2'd1);
    wait_done();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
